// File: rtl/rob_alloc.sv
// ============================================================================
// rob_alloc -- dispatch-side reorder-buffer allocator
//
// Hands out in-order ROB numbers to up to two dispatched instructions per
// cycle and builds their ROB issue rows for the complete/retire stage. It
// tracks occupancy from the two-lane retire stream coming back from that
// stage, stalls dispatch when the ROB cannot take the whole request, and
// supports a full pipeline flush.
//
// Parameters
//   ROB_DEPTH  number of ROB entries (power of two)
//   PTR_W      log2(ROB_DEPTH)
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_dispatch_valid[0:1]      dispatch request per lane (lane 0 older)
//   i_PRegAddrDst[0:1]         renamed destination register
//   i_OldPRegAddrDst[0:1]      previous mapping of the destination
//   i_RegWrite/i_MemWrite[0:1] control bits copied into the row
//   o_dispatch_stall           combinational, no lane accepted when 1
//   o_rob_row[0:1]             registered ROB issue rows
//   i_retire_valid[0:1]        retire notifications
//   i_retire_ROBNumber[0:1]    ROB number retired on each lane
//   i_flush                    discard all in-flight entries
//   o_count, o_full, o_empty   occupancy status (registered)
//   o_retire_error             sticky retire-order / underflow error
//
// Build option
//   ROB_ALLOC_CHECK_EN  when defined, retire numbers are checked against the
//                       head pointer and underflow retires are rejected;
//                       either event sets o_retire_error until reset. When
//                       undefined, no checking logic exists, the error output
//                       is tied low and underflow saturates the count at 0.
// ============================================================================

package rob_pkg;
    localparam int PREG_W   = 6;
    localparam int DATA_W   = 32;
    localparam int ROBNUM_W = 4;   // must match PTR_W of rob_alloc

    typedef struct packed {
        logic                valid;
        logic                complete;
        logic [DATA_W-1:0]   data;
        logic [PREG_W-1:0]   PRegAddrDst;
        logic [PREG_W-1:0]   OldPRegAddrDst;
        logic                RegWrite;
        logic                MemWrite;
        logic [ROBNUM_W-1:0] ROBNumber;
    } rob_row_struct;
endpackage

module rob_alloc
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int PTR_W     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dispatch_valid   [0:1],
    input  logic [PREG_W-1:0]   i_PRegAddrDst      [0:1],
    input  logic [PREG_W-1:0]   i_OldPRegAddrDst   [0:1],
    input  logic                i_RegWrite         [0:1],
    input  logic                i_MemWrite         [0:1],
    output logic                o_dispatch_stall,
    output rob_row_struct       o_rob_row          [0:1],
    input  logic                i_retire_valid     [0:1],
    input  logic [PTR_W-1:0]    i_retire_ROBNumber [0:1],
    input  logic                i_flush,
    output logic [PTR_W:0]      o_count,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_retire_error
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(ROB_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    // ------------------------------------------------------------------
    // Request / retire counts and stall
    // ------------------------------------------------------------------
    logic [1:0]       w_req;
    logic [1:0]       w_ret;
    logic [PTR_W:0]   w_free;
    logic             w_stall;
    logic [1:0]       w_acc_cnt;
    logic             w_underflow;
    logic [1:0]       w_head_step;
    logic [PTR_W:0]   w_count_after_ret;
    logic             w_retire_error;
    logic [PTR_W-1:0] w_lane_num [0:1];

    assign w_req = {1'b0, i_dispatch_valid[0]} + {1'b0, i_dispatch_valid[1]};
    assign w_ret = {1'b0, i_retire_valid[0]}   + {1'b0, i_retire_valid[1]};

    // Space check uses only the registered count: a retire in the same
    // cycle does not free room for this cycle's dispatch.
    assign w_free  = DEPTH_C - r_count;
    assign w_stall = i_flush || (w_free < {{(PTR_W-1){1'b0}}, w_req});

    // All-or-nothing: either every requesting lane is taken or none is.
    assign w_acc_cnt = w_stall ? 2'd0 : w_req;

    assign w_underflow = (r_count < {{(PTR_W-1){1'b0}}, w_ret});

    // The oldest valid lane gets tail; lane 1 only gets tail+1 when lane 0
    // is also dispatching. Pointer arithmetic wraps on the PTR_W width.
    always_comb begin
        w_lane_num[0] = r_tail;
        w_lane_num[1] = r_tail + PTR_W'(i_dispatch_valid[0]);
    end

`ifdef ROB_ALLOC_CHECK_EN
    // ------------------------------------------------------------------
    // Retire-order and underflow checking
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] w_exp_num [0:1];
    logic             w_mismatch;
    logic             r_retire_error;

    always_comb begin
        w_exp_num[0] = r_head;
        // Lane 1 retiring alone must carry the head number itself.
        w_exp_num[1] = r_head + PTR_W'(i_retire_valid[0]);
        w_mismatch   = (i_retire_valid[0] && (i_retire_ROBNumber[0] != w_exp_num[0]))
                    || (i_retire_valid[1] && (i_retire_ROBNumber[1] != w_exp_num[1]));
    end

    // A mismatched retire still moves head/count; an underflow retire
    // is dropped entirely.
    assign w_head_step       = w_underflow ? 2'd0 : w_ret;
    assign w_count_after_ret = w_underflow ? r_count
                                           : (r_count - {{(PTR_W-1){1'b0}}, w_ret});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retire_error <= 1'b0;
        end else if (!i_flush && (w_mismatch || w_underflow)) begin
            r_retire_error <= 1'b1;
        end
    end

    assign w_retire_error = r_retire_error;
`else
    // Retire numbers are not inspected in this build.
    logic w_unused_retire_num;
    assign w_unused_retire_num = &{1'b0, i_retire_ROBNumber[0], i_retire_ROBNumber[1]};

    assign w_head_step       = w_ret;
    assign w_count_after_ret = w_underflow ? '0
                                           : (r_count - {{(PTR_W-1){1'b0}}, w_ret});
    assign w_retire_error    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pointer and occupancy registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            // Everything in flight is discarded; head stays where the
            // retire stream left it so numbering continues from there.
            r_tail  <= r_head;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_head_step);
            r_tail  <= r_tail + PTR_W'(w_acc_cnt);
            r_count <= w_count_after_ret + {{(PTR_W-1){1'b0}}, w_acc_cnt};
        end
    end

    // ------------------------------------------------------------------
    // Row build, one registered row per lane
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            rob_row_struct w_row_next;
            rob_row_struct r_rob_row;

            // Stalled (including flush) or idle lanes emit the zero row.
            always_comb begin
                w_row_next = '0;
                if (!w_stall && i_dispatch_valid[gi]) begin
                    w_row_next.valid          = 1'b1;
                    w_row_next.complete       = 1'b0;
                    w_row_next.data           = '0;
                    w_row_next.PRegAddrDst    = i_PRegAddrDst[gi];
                    w_row_next.OldPRegAddrDst = i_OldPRegAddrDst[gi];
                    w_row_next.RegWrite       = i_RegWrite[gi];
                    w_row_next.MemWrite       = i_MemWrite[gi];
                    w_row_next.ROBNumber      = ROBNUM_W'(w_lane_num[gi]);
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rob_row <= '0;
                end else begin
                    r_rob_row <= w_row_next;
                end
            end

            assign o_rob_row[gi] = r_rob_row;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_dispatch_stall = w_stall;
    assign o_count          = r_count;
    assign o_full           = (r_count == DEPTH_C);
    assign o_empty          = (r_count == '0);
    assign o_retire_error   = w_retire_error;

endmodule

// File: tb/tb_rob_alloc.sv
module tb_rob_alloc;
    import rob_pkg::*;

    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dv   [0:1];
    logic [5:0]    preg [0:1];
    logic [5:0]    opreg[0:1];
    logic          rw   [0:1];
    logic          mw   [0:1];
    logic          stall;
    rob_row_struct rob_row [0:1];
    logic          rv   [0:1];
    logic [PW-1:0] rnum [0:1];
    logic          flush;
    logic [PW:0]   count;
    logic          full, empty, rerr;

    always #5 clk = ~clk;

    rob_alloc #(.ROB_DEPTH(DEPTH), .PTR_W(PW)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_dispatch_valid   (dv),
        .i_PRegAddrDst      (preg),
        .i_OldPRegAddrDst   (opreg),
        .i_RegWrite         (rw),
        .i_MemWrite         (mw),
        .o_dispatch_stall   (stall),
        .o_rob_row          (rob_row),
        .i_retire_valid     (rv),
        .i_retire_ROBNumber (rnum),
        .i_flush            (flush),
        .o_count            (count),
        .o_full             (full),
        .o_empty            (empty),
        .o_retire_error     (rerr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard of expected rows
    typedef struct {
        int            due;
        int            lane;
        rob_row_struct row;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Reference model: ROB as a queue of outstanding numbers
    int m_q[$];
    int m_head;
    int m_tail;
    bit m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every row the DUT presents with the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                total++; bad++;
                $display("FAIL row_missing: got none expected lane %0d row %0h", sb[0].lane, sb[0].row);
                void'(sb.pop_front());
            end
            for (int l = 0; l < 2; l++) begin
                if (rob_row[l].valid === 1'b1) begin
                    if (sb.size() == 0 || sb[0].due != cyc) begin
                        total++; bad++;
                        $display("FAIL row_unexpected: got lane %0d row %0h expected none", l, rob_row[l]);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("row_lane", 64'(l), 64'(mon_e.lane));
                        chk("row_value", 64'(rob_row[l]), 64'(mon_e.row));
                        $display("row cyc=%0d lane=%0d rob=%0d preg=%0d", cyc, l, rob_row[l].ROBNumber, rob_row[l].PRegAddrDst);
                    end
                end else begin
                    chk("row_idle_zero", 64'(rob_row[l]), 64'd0);
                end
            end
        end
    end

    task automatic zero_inputs();
        for (int l = 0; l < 2; l++) begin
            dv[l] = 0; preg[l] = 0; opreg[l] = 0; rw[l] = 0; mw[l] = 0;
            rv[l] = 0; rnum[l] = 0;
        end
        flush = 0;
    endtask

    task automatic model_clear();
        sb.delete();
        m_q.delete();
        m_head = 0; m_tail = 0; m_err = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_err",   64'(rerr),  64'd0);
        chk("rst_row0",  64'(rob_row[0]), 64'd0);
        chk("rst_row1",  64'(rob_row[1]), 64'd0);
        rst_n = 1'b1;
    endtask

    // One cycle of stimulus; expected rows go to the scoreboard.
    task automatic step(input bit d0, input bit d1, input bit r0, input bit r1,
                        input bit fl, input bit corrupt);
        int            req, nret;
        bit            exp_stall, uf;
        rob_row_struct row;
        exp_t          e;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            preg[l]  = 6'($urandom_range(0, 63));
            opreg[l] = 6'($urandom_range(0, 63));
            rw[l]    = 1'($urandom_range(0, 1));
            mw[l]    = 1'($urandom_range(0, 1));
        end
        dv[0] = d0; dv[1] = d1;
        rv[0] = r0; rv[1] = r1;
        // In-order retire: oldest retiring lane carries head
        rnum[0] = PW'(m_head);
        rnum[1] = PW'(r0 ? (m_head + 1) % DEPTH : m_head);
        if (corrupt) begin
            if (r0) rnum[0] = rnum[0] + 1'b1;
            else    rnum[1] = rnum[1] + 1'b1;
        end
        flush = fl;
        #1;
        req       = int'(d0) + int'(d1);
        nret      = int'(r0) + int'(r1);
        exp_stall = fl || ((DEPTH - m_q.size()) < req);
        chk("stall", 64'(stall), 64'(exp_stall));
        $display("txn cyc=%0d dv=%0d%0d rv=%0d%0d flush=%0d stall_exp=%0d", cyc, d0, d1, r0, r1, fl, exp_stall);

        if (fl) begin
            m_q.delete();
            m_tail = m_head;
        end else begin
            uf = nret > m_q.size();
`ifdef ROB_ALLOC_CHECK_EN
            if (uf) begin
                m_err = 1;
            end else begin
                if (corrupt) m_err = 1;
                repeat (nret) void'(m_q.pop_front());
                m_head = (m_head + nret) % DEPTH;
            end
`else
            for (int k = 0; k < nret; k++)
                if (m_q.size() > 0) void'(m_q.pop_front());
            m_head = (m_head + nret) % DEPTH;
`endif
            if (!exp_stall) begin
                for (int l = 0; l < 2; l++) begin
                    if ((l == 0 && d0) || (l == 1 && d1)) begin
                        row = '0;
                        row.valid          = 1'b1;
                        row.PRegAddrDst    = preg[l];
                        row.OldPRegAddrDst = opreg[l];
                        row.RegWrite       = rw[l];
                        row.MemWrite       = mw[l];
                        row.ROBNumber      = ROBNUM_W'(m_tail);
                        e.due  = cyc + 1;
                        e.lane = l;
                        e.row  = row;
                        sb.push_back(e);
                        m_q.push_back(m_tail);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        chk("count", 64'(count), 64'(m_q.size()));
        chk("full",  64'(full),  64'(m_q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(m_q.size() == 0));
        chk("retire_error", 64'(rerr), 64'(m_err));
        zero_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        model_clear();
        reset_dut();

        // Fill: 8 dual dispatches -> numbers 0..15, then a stalled 9th
        repeat (8) step(1, 1, 0, 0, 0, 0);
        chk("full_after_fill", 64'(full), 64'd1);
        chk("count_after_fill", 64'(count), 64'd16);
        step(1, 1, 0, 0, 0, 0);

        // count 15, dual request with same-cycle retire: stall, count 14
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("count_retire_no_forward", 64'(count), 64'd14);
        step(1, 1, 0, 0, 0, 0);
        chk("count_refill", 64'(count), 64'd16);

        // Drain, refill to tail=15 head=4 count=11, then wrap
        repeat (8) step(0, 0, 1, 1, 0, 0);
        repeat (6) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("count_after_wrap", 64'(count), 64'd13);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);            // lone lane 1 gets tail=3
        chk("count_lane1_only", 64'(count), 64'd16);

        // Flush at count=6, head=2 with a dual dispatch
        reset_dut();
        repeat (4) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("flush_empty", 64'(empty), 64'd1);
        step(1, 1, 0, 0, 0, 0);            // numbering resumes at head=2

        // Randomized traffic with legal in-order retires
        for (int i = 0; i < 400; i++) begin
            bit a, b, c, d, f;
            int k;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 2);
            if (k > m_q.size()) k = m_q.size();
            c = 0; d = 0;
            if (k == 2) begin c = 1; d = 1; end
            else if (k == 1) begin c = 1'($urandom_range(0, 1)); d = !c; end
            f = ($urandom_range(0, 31) == 0);
            step(a, b, c, d, f, 0);
        end

        // Asynchronous reset mid-operation drops rows at once
        step(1, 1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_row0",  64'(rob_row[0]), 64'd0);
        chk("async_rst_row1",  64'(rob_row[1]), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0, 0);

        // Retire-order error: head=5, retire lane 0 with number 6
        reset_dut();
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        // Underflow retire at count 0
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        reset_dut();
        step(1, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_alloc.md
# rob_alloc

Dispatch-side reorder-buffer allocator: the producer of the ROB issue rows consumed by the complete/retire stage. It assigns in-order ROB numbers to up to two dispatched instructions per cycle and builds their `rob_row_struct` entries. It tracks ROB occupancy from the two-lane retire stream returned by the complete/retire stage. It stalls dispatch when the ROB lacks space and supports a full pipeline flush.

## Interface
Parameters:
- `ROB_DEPTH`, default 16: number of ROB entries; must be a power of two.
- `PTR_W`, default 4: pointer width, equal to log2(`ROB_DEPTH`).

Ports:
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_dispatch_valid[0:1]`, input, 1 each: dispatch request on each lane; lane 0 is older.
- `i_PRegAddrDst[0:1]`, `i_OldPRegAddrDst[0:1]`, input, `rob_row_struct` field widths: renamed destination register and the previous mapping of that destination.
- `i_RegWrite[0:1]`, `i_MemWrite[0:1]`, input, 1 each: control bits copied into the row.
- `o_dispatch_stall`, output, 1: combinational; when 1, no lane is accepted this cycle.
- `o_rob_row[0:1]`, output, `rob_row_struct`: registered ROB issue rows.
- `i_retire_valid[0:1]`, input, 1 each: retire notification from the complete/retire stage, one per retire lane.
- `i_retire_ROBNumber[0:1]`, input, `PTR_W`: ROB number being retired on each lane.
- `i_flush`, input, 1: discard all in-flight entries.
- `o_count`, output, `PTR_W+1`: current occupancy, range 0..`ROB_DEPTH`.
- `o_full`, `o_empty`, output, 1 each: `o_count`==`ROB_DEPTH` and `o_count`==0 respectively.
- `o_retire_error`, output, 1: sticky flag for retire-order errors.

## Operation
- State: `head` (`PTR_W`), `tail` (`PTR_W`), `count` (`PTR_W+1`).
- Request count: `req` = number of asserted `i_dispatch_valid` lanes (0–2).
- Stall condition: `o_dispatch_stall` = (`ROB_DEPTH` − `count`) < `req`, or `i_flush`=1.
  - All-or-nothing: a cycle never accepts only one lane of a two-lane request.
  - The stall is computed from the registered `count`. Same-cycle retires are not forwarded into it.
- Allocation, when not stalled:
  - The first valid lane in lane order receives ROB number `tail`; a second valid lane receives `tail`+1.
  - Pointers wrap modulo `ROB_DEPTH`, so `tail` 15 with two lanes assigns 15 and 0 and leaves `tail`=1.
  - If only lane 1 is valid, it receives `tail`.
  - `tail` advances by `req`.
- Row build for each accepted lane:
  - `valid`=1, `complete`=0, `data`=0.
  - `PRegAddrDst`, `OldPRegAddrDst`, `RegWrite`, `MemWrite` copied from the lane inputs.
  - `ROBNumber` set to the assigned number.
- Unaccepted or invalid lanes output the all-zero row (`valid`=0).
- Retire: `ret` = number of asserted `i_retire_valid` lanes.
  - Retire is in order: lane 0 must equal `head`; lane 1 must equal `head`+1 when lane 0 is also valid, or `head` when lane 1 is valid alone.
  - `head` advances by `ret`.
- Count update: `count` next = `count` + accepted − `ret`. Allocation and retire in the same cycle are both applied.
- Retire when `count` < `ret` (underflow): the retire is ignored and `o_retire_error` is set (check build only).
- Flush: `tail` ← `head`, `count` ← 0, both `o_rob_row` lanes invalid next cycle. Flush overrides same-cycle dispatch and retire; `head` is unchanged.
- Reset values: `head`=`tail`=`count`=0, both `o_rob_row` lanes all-zero, `o_empty`=1, `o_full`=0, `o_retire_error`=0, and `o_dispatch_stall` follows the stall condition for `count`=0.

## Timing
- Dispatch latency: a request accepted at edge N appears on `o_rob_row` after edge N, for exactly one cycle.
- `o_count`, `o_full`, `o_empty` reflect the accept/retire of edge N in the cycle after it.
- `o_dispatch_stall` is combinational from `i_dispatch_valid`, `i_flush` and registered `count`; it has no dependence on the retire inputs.
- Reset is honoured mid-operation: in-flight rows drop immediately and asynchronously; the first accept is possible at the first edge after deassertion.
- Full throughput: 2 allocations and 2 retires per cycle, sustained.

## Configuration
- `ROB_ALLOC_CHECK_EN` defined:
  - Retire-order checking and underflow checking are compiled in.
  - A mismatched `i_retire_ROBNumber` or an underflow sets `o_retire_error`, which stays set until reset.
  - A mismatched retire still advances `head`/`count`; an underflow retire does not.
- `ROB_ALLOC_CHECK_EN` undefined:
  - No comparison logic; `o_retire_error` is tied to 0.
  - `i_retire_ROBNumber` is ignored and `head` advances by `ret`.
  - Underflow saturates `count` at 0.

## Test plan
- Reset, then both lanes valid for 8 cycles, no retire → ROB numbers 0..15 assigned in order; `o_count`=16, `o_full`=1; a 9th dual request sees `o_dispatch_stall`=1 and emits no valid rows.
- `count`=15, dual request → stall, no partial accept; same cycle, retire lane 0 with `head` → next cycle `count`=14; following cycle the dual request is accepted, `count`=16.
- `tail`=15, `head`=4, `count`=11, dual dispatch → numbers 15 and 0, `tail`=1, `count`=13.
- Only lane 1 valid at `tail`=3 → lane 1 row has `ROBNumber`=3 and `valid`=1; lane 0 row has `valid`=0; `tail`=4.
- `i_flush` with a simultaneous dual dispatch at `count`=6, `head`=2 → no rows emitted, `count`=0, `tail`=2, `o_empty`=1.
- Check build, `head`=5, retire lane 0 with `ROBNumber`=6 → `o_retire_error`=1 and it stays 1; with the macro undefined, the same stimulus leaves `o_retire_error`=0.
